// File: rtl/snake_move_ctrl_if.sv
// Handshake bundle between the snake movement sequencer and the rest of the game.
// master = game/collision side driving requests, slave = snake_move_ctrl.
interface snake_move_ctrl_if;
    logic        start;
    logic [3:0]  dir_req;
    logic        food_hit;
    logic        self_hit;
    logic [11:0] head_x;
    logic [11:0] head_y;
    logic        shift_en;
    logic [5:0]  body_len;
    logic        game_over;
    logic [1:0]  state;

    modport master (
        output start, dir_req, food_hit, self_hit,
        input  head_x, head_y, shift_en, body_len, game_over, state
    );

    modport slave (
        input  start, dir_req, food_hit, self_hit,
        output head_x, head_y, shift_en, body_len, game_over, state
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake movement sequencer: move tick, direction latch, head stepping, growth and game FSM.
// Optional WALL_WRAP_EN: an off-field step wraps to the opposite edge instead of killing.
//
// state  | meaning
// IDLE   | waiting for a rising edge on start
// RUN    | game active, head steps on every move tick
// DEAD   | head/len/dir frozen until start rises again
module snake_move_ctrl #(
    parameter int TICK_DIV = 2500000,
    parameter int STEP     = 10,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 630,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 470,
    parameter int HEAD_X0  = 320,
    parameter int HEAD_Y0  = 205,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 63
) (
    input  logic              CLK_50,
    input  logic              reset,
    snake_move_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    localparam logic [3:0] D_UP    = 4'b1000;
    localparam logic [3:0] D_DOWN  = 4'b0100;
    localparam logic [3:0] D_LEFT  = 4'b0010;
    localparam logic [3:0] D_RIGHT = 4'b0001;

    localparam int             CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  TC      = CW'(TICK_DIV - 1);
    localparam logic [12:0]    STEP13  = 13'(STEP);
    localparam logic [12:0]    XMIN13  = 13'(X_MIN);
    localparam logic [12:0]    XMAX13  = 13'(X_MAX);
    localparam logic [12:0]    YMIN13  = 13'(Y_MIN);
    localparam logic [12:0]    YMAX13  = 13'(Y_MAX);

    state_t        state_q, state_d;
    logic          start_q;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    dir_q, dir_d;
    logic [3:0]    pend_q, pend_d;
    logic [11:0]   head_x_q, head_x_d;
    logic [11:0]   head_y_q, head_y_d;
    logic [5:0]    len_q, len_d;
    logic          grow_q, grow_d;
    logic          shift_q, shift_d;

    logic          start_rise;
    logic          tick;
    logic          dir_ok;
    logic          off_field;
    logic          wall_kill;
    logic [12:0]   hx13, hy13, nx13, ny13;

    assign start_rise = bus.start & ~start_q;
    assign tick       = (tick_cnt_q == TC);
    assign dir_ok     = $onehot(bus.dir_req) &&
                        (bus.dir_req != {dir_q[2], dir_q[3], dir_q[0], dir_q[1]});
    assign hx13       = {1'b0, head_x_q};
    assign hy13       = {1'b0, head_y_q};

    // Candidate next head along the pending direction; off-field steps get the wrap target.
    always_comb begin
        nx13      = hx13;
        ny13      = hy13;
        off_field = 1'b0;
        unique case (pend_q)
            D_UP: begin
                if (hy13 < YMIN13 + STEP13) begin
                    off_field = 1'b1;
                    ny13      = YMAX13;
                end else begin
                    ny13 = hy13 - STEP13;
                end
            end
            D_DOWN: begin
                if (hy13 + STEP13 > YMAX13) begin
                    off_field = 1'b1;
                    ny13      = YMIN13;
                end else begin
                    ny13 = hy13 + STEP13;
                end
            end
            D_LEFT: begin
                if (hx13 < XMIN13 + STEP13) begin
                    off_field = 1'b1;
                    nx13      = XMAX13;
                end else begin
                    nx13 = hx13 - STEP13;
                end
            end
            default: begin
                if (hx13 + STEP13 > XMAX13) begin
                    off_field = 1'b1;
                    nx13      = XMIN13;
                end else begin
                    nx13 = hx13 + STEP13;
                end
            end
        endcase
    end

`ifdef WALL_WRAP_EN
    assign wall_kill = 1'b0;
`else
    assign wall_kill = off_field;
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        len_d      = len_q;
        grow_d     = grow_q;
        shift_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                if (start_rise) state_d = S_RUN;
            end
            S_RUN: begin
                // Exits take priority over the tick: no move, no shift, no growth.
                if (!bus.start) begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                end else if (bus.self_hit || (tick && wall_kill)) begin
                    state_d    = S_DEAD;
                    tick_cnt_d = '0;
                end else begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                    if (dir_ok) pend_d = bus.dir_req;
                    grow_d = grow_q | bus.food_hit;
                    if (tick) begin
                        dir_d    = pend_q;
                        head_x_d = nx13[11:0];
                        head_y_d = ny13[11:0];
                        shift_d  = 1'b1;
                        grow_d   = bus.food_hit;
                        if (grow_q && (len_q < 6'(MAX_LEN))) len_d = len_q + 6'd1;
                    end
                end
            end
            S_DEAD: begin
                tick_cnt_d = '0;
                if (start_rise) begin
                    state_d  = S_RUN;
                    dir_d    = D_RIGHT;
                    pend_d   = D_RIGHT;
                    head_x_d = 12'(HEAD_X0);
                    head_y_d = 12'(HEAD_Y0);
                    len_d    = 6'(INIT_LEN);
                    grow_d   = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            tick_cnt_q <= '0;
            dir_q      <= D_RIGHT;
            pend_q     <= D_RIGHT;
            head_x_q   <= 12'(HEAD_X0);
            head_y_q   <= 12'(HEAD_Y0);
            len_q      <= 6'(INIT_LEN);
            grow_q     <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= bus.start;
            tick_cnt_q <= tick_cnt_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            len_q      <= len_d;
            grow_q     <= grow_d;
            shift_q    <= shift_d;
        end
    end

    assign bus.head_x    = head_x_q;
    assign bus.head_y    = head_y_q;
    assign bus.shift_en  = shift_q;
    assign bus.body_len  = len_q;
    assign bus.game_over = (state_q == S_DEAD);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: directed scenarios plus random play against a coordinate-level model.
module tb_snake_move_ctrl;

    localparam int TICK_DIV = 4;
    localparam int STEP     = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    snake_move_ctrl_if sif();

    snake_move_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .CLK_50 (clk),
        .reset  (rst),
        .bus    (sif)
    );

    always #5 clk = ~clk;

    // Model: state 0 idle / 1 run / 2 dead; direction index 0 up, 1 down, 2 left, 3 right.
    int m_st, m_hx, m_hy, m_dir, m_pend, m_len, m_cnt;
    bit m_grow, m_shift, m_sprev;

    function automatic int dx(int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int dy(int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    function automatic int req_idx(logic [3:0] r);
        int ones = 0;
        int idx  = -1;
        for (int b = 0; b < 4; b++) begin
            if (r[b]) begin
                ones++;
                idx = 3 - b;
            end
        end
        return (ones == 1) ? idx : -1;
    endfunction

    task automatic model_restore();
        m_hx = 320; m_hy = 205; m_dir = 3; m_pend = 3; m_len = 3; m_cnt = 0; m_grow = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input logic [3:0] dr,
                              input bit fh, input bit sh);
        bit rise, tick, wall;
        int nx, ny, rq, old_pend;
        m_shift = 0;
        if (r) begin
            m_st = 0; m_sprev = 0;
            model_restore();
            return;
        end
        rise    = s && !m_sprev;
        m_sprev = s;
        case (m_st)
            0: if (rise) begin m_st = 1; m_cnt = 0; end
            1: begin
                tick = (m_cnt == TICK_DIV - 1);
                nx = m_hx + dx(m_pend) * STEP;
                ny = m_hy + dy(m_pend) * STEP;
                wall = (nx < 0) || (nx > 630) || (ny < 0) || (ny > 470);
`ifdef WALL_WRAP_EN
                if (nx < 0) nx = 630; else if (nx > 630) nx = 0;
                if (ny < 0) ny = 470; else if (ny > 470) ny = 0;
                wall = 0;
`endif
                if (!s) begin
                    m_st = 0; m_cnt = 0;
                end else if (sh || (tick && wall)) begin
                    m_st = 2; m_cnt = 0;
                end else begin
                    m_cnt    = (m_cnt + 1) % TICK_DIV;
                    old_pend = m_pend;
                    rq       = req_idx(dr);
                    if (rq >= 0 && rq != (m_dir ^ 1)) m_pend = rq;
                    if (tick) begin
                        m_dir = old_pend; m_hx = nx; m_hy = ny; m_shift = 1;
                        if (m_grow && m_len < 63) m_len++;
                        m_grow = fh;
                    end else begin
                        m_grow = m_grow | fh;
                    end
                end
            end
            default: if (rise) begin m_st = 1; model_restore(); end
        endcase
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input logic [3:0] dr,
                       input bit fh, input bit sh);
        rst = r; sif.start = s; sif.dir_req = dr; sif.food_hit = fh; sif.self_hit = sh;
        @(posedge clk);
        model_step(r, s, dr, fh, sh);
        #1;
        chk("head_x",    int'(sif.head_x),    m_hx);
        chk("head_y",    int'(sif.head_y),    m_hy);
        chk("shift_en",  int'(sif.shift_en),  int'(m_shift));
        chk("body_len",  int'(sif.body_len),  m_len);
        chk("game_over", int'(sif.game_over), int'(m_st == 2));
        chk("state",     int'(sif.state),     m_st);
    endtask

    function automatic logic [3:0] onehot_of(int d);
        logic [3:0] v = 4'b0001;
        return v << (3 - d);
    endfunction

    initial begin
        int nxt[4];
        int waited;
        logic [3:0] dr;
        nxt[0] = 3; nxt[1] = 2; nxt[2] = 0; nxt[3] = 1;
        sif.start = 0; sif.dir_req = 0; sif.food_hit = 0; sif.self_hit = 0;
        m_st = 0; m_sprev = 0; m_shift = 0; model_restore();

        // reset, then start: steps right every TICK_DIV cycles
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0);

        // reverse request ignored, then turn up
        for (int i = 0; i < 8; i++) cyc(0, 1, 4'b0010, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 4'b1000, 0, 0);

        // food two cycles before a tick
        waited = 0;
        while (!(m_st == 1 && m_cnt == TICK_DIV - 3) && waited < 20) begin
            cyc(0, 1, 0, 0, 0); waited++;
        end
        if (waited >= 20) chk("food_align_timeout", 0, 1);
        cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

        // circle in place with constant food: grows to 63 and holds
        for (int i = 0; i < 300; i++) cyc(0, 1, onehot_of(nxt[m_dir]), 1, 0);

        // fresh game, run right into the wall
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 140; i++) cyc(0, 1, 0, 0, 0);

        // restart, then self_hit with food on the same cycle
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);

        // reset exactly when a tick is due
        waited = 0;
        while (!(m_st == 1 && m_cnt == TICK_DIV - 1) && waited < 20) begin
            cyc(0, 1, 0, 0, 0); waited++;
        end
        if (waited >= 20) chk("tick_align_timeout", 0, 1);
        cyc(1, 1, 0, 0, 0);

        // random play
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: dr = 4'b0000;
                6, 7, 8:          dr = onehot_of(int'($urandom_range(0, 3)));
                default:          dr = 4'($urandom_range(0, 15));
            endcase
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) != 0), dr,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
